// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCount,
    StData,
    StWrite,
    StCsum,
    StDone
  } loader_state_e;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  function automatic int unsigned BYTES_PER_WORD(input int unsigned dwidth);
    return dwidth / 8;
  endfunction

endpackage

// File: rtl/imem_word_asm.sv
// Little-endian word assembler: each byte lands in lane [byte index], last_o flags the final lane.
module imem_word_asm
  import imem_loader_pkg::*;
#(
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clear_i,
  input  logic              shift_i,
  input  logic [7:0]        byte_i,
  output logic [DWIDTH-1:0] word_o,
  output logic              last_o
);

  localparam int unsigned Bpw  = BYTES_PER_WORD(DWIDTH);
  localparam int unsigned IdxW = (Bpw > 1) ? $clog2(Bpw) : 1;

  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DWIDTH-1:0] word_q, word_d;

  assign last_o = (idx_q == IdxW'(Bpw - 1));
  assign word_o = word_q;

  // Next lane index and lane write.
  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear_i) begin
      idx_d = '0;
    end else if (shift_i) begin
      word_d[{idx_q, 3'b000} +: 8] = byte_i;
      idx_d = last_o ? '0 : idx_q + 1'b1;
    end
  end

  // Lane index and word register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the instruction memory; holds the core while a frame is in flight.
// Optional trailing XOR checksum byte when IMEM_LOADER_CSUM_EN is defined.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 5,
  parameter logic [7:0]  SYNC   = SYNC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              abort,
  output logic              imem_we,
  output logic [AWIDTH-1:0] imem_waddr,
  output logic [DWIDTH-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [8:0] MaxWords = 9'(1 << AWIDTH);

  loader_state_e     state_q, state_d;
  logic [8:0]        n_q, n_d;
  logic [AWIDTH-1:0] widx_q, widx_d;
  logic              err_q, err_d;
  logic              accept, last_word;
  logic              asm_clear, asm_shift, asm_last;
  logic [DWIDTH-1:0] asm_word;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  assign in_ready   = !(state_q inside {StWrite, StDone});
  assign cpu_hold   = state_q inside {StCount, StData, StWrite, StCsum};
  assign done       = (state_q == StDone);
  // abort also suppresses a write that is being presented this cycle
  assign imem_we    = (state_q == StWrite) && !abort;
  assign imem_waddr = widx_q;
  assign imem_wdata = asm_word;
  assign err        = err_q;
  assign accept     = in_valid && in_ready;
  assign last_word  = (9'(widx_q) == n_q - 9'd1);

  imem_word_asm #(
    .DWIDTH(DWIDTH)
  ) u_asm (
    .clk_i  (clk),
    .reset_i(reset),
    .clear_i(asm_clear),
    .shift_i(asm_shift),
    .byte_i (in_data),
    .word_o (asm_word),
    .last_o (asm_last)
  );

  // Frame FSM: next state, counters, error flag and assembler controls.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    widx_d    = widx_q;
    err_d     = err_q;
    asm_clear = 1'b0;
    asm_shift = 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
    csum_d    = csum_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept && in_data == SYNC) begin
          err_d   = 1'b0;
          state_d = StCount;
        end
      end
      StCount: begin
        if (accept) begin
          if (in_data == 8'd0 || {1'b0, in_data} > MaxWords) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            n_d       = {1'b0, in_data};
            widx_d    = '0;
            asm_clear = 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
            csum_d    = 8'd0;
`endif
            state_d   = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          asm_shift = 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
          csum_d    = csum_q ^ in_data;
`endif
          if (asm_last) state_d = StWrite;
        end
      end
      StWrite: begin
        if (last_word) begin
`ifdef IMEM_LOADER_CSUM_EN
          state_d = StCsum;
`else
          state_d = StDone;
`endif
        end else begin
          widx_d  = widx_q + 1'b1;
          state_d = StData;
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      StCsum: begin
        if (accept) begin
          if (in_data == csum_q) begin
            state_d = StDone;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // abort wins over any byte accepted in the same cycle
    if (abort) begin
      state_d   = StIdle;
      err_d     = err_q;
      asm_shift = 1'b0;
      asm_clear = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      n_q     <= '0;
      widx_q  <= '0;
      err_q   <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      widx_q  <= widx_d;
      err_q   <= err_d;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (default build, or with IMEM_LOADER_CSUM_EN).
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        abort = 1'b0;
  logic        imem_we;
  logic [4:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  // Write log and event counters, sampled on the falling edge.
  logic [4:0]  log_addr [0:255];
  logic [31:0] log_data [0:255];
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          hold_bad = 0;
  logic        hold_watch = 1'b0;
  logic [7:0]  csum;

  imem_loader #(
    .DWIDTH(32),
    .AWIDTH(5),
    .SYNC  (8'hA5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .abort     (abort),
    .imem_we   (imem_we),
    .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we && wr_cnt < 256) begin
      log_addr[wr_cnt] = imem_waddr;
      log_data[wr_cnt] = imem_wdata;
      wr_cnt++;
    end
    if (done) done_cnt++;
    if (hold_watch && !done && !cpu_hold) hold_bad++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one byte after `gap` idle cycles; returns 1ns after the accepting edge.
  task automatic send(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int j = 0; j < 4; j++) begin
      send(w[8*j +: 8], gap);
      csum = csum ^ w[8*j +: 8];
    end
  endtask

  task automatic send_csum();
`ifdef IMEM_LOADER_CSUM_EN
    send(csum, 0);
`endif
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, {63'd0, done}, 64'd1);
    #1;
    hold_watch = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int          wb, db;
    logic [31:0] w;

    // Reset values while reset is held.
    #2;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_imem_we", {63'd0, imem_we}, 64'd0);
    check("rst_waddr", {59'd0, imem_waddr}, 64'd0);
    check("rst_wdata", {32'd0, imem_wdata}, 64'd0);
    check("rst_cpu_hold", {63'd0, cpu_hold}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 1: single word 0x00000013.
    wb = wr_cnt; db = done_cnt; csum = 8'd0;
    send(8'h42, 0);  // noise in IDLE is discarded
    send(8'hA5, 0);
    check("t1_hold_after_sync", {63'd0, cpu_hold}, 64'd1);
    send(8'h01, 0);
    send_word(32'h0000_0013, 0);
    check("t1_we_latency", {63'd0, imem_we}, 64'd1);
    check("t1_ready_in_write", {63'd0, in_ready}, 64'd0);
    check("t1_waddr", {59'd0, imem_waddr}, 64'd0);
    check("t1_wdata", {32'd0, imem_wdata}, 64'h13);
    send_csum();
    wait_done("t1_done_seen");
    check("t1_writes", 64'(wr_cnt - wb), 64'd1);
    check("t1_log_addr", {59'd0, log_addr[wb]}, 64'd0);
    check("t1_log_data", {32'd0, log_data[wb]}, 64'h13);
    check("t1_done_once", 64'(done_cnt - db), 64'd1);
    check("t1_err", {63'd0, err}, 64'd0);
    check("t1_hold_end", {63'd0, cpu_hold}, 64'd0);

    // 2: full 32-word frame.
    wb = wr_cnt; db = done_cnt; csum = 8'd0;
    send(8'hA5, 0);
    hold_watch = 1'b1;
    send(8'h20, 0);
    for (int k = 0; k < 32; k++) begin
      w = {8'(k), 8'hC3, 8'(k * 3), 8'(255 - k)};
      send_word(w, 0);
    end
    send_csum();
    wait_done("t2_done_seen");
    check("t2_writes", 64'(wr_cnt - wb), 64'd32);
    for (int k = 0; k < 32; k++) begin
      w = {8'(k), 8'hC3, 8'(k * 3), 8'(255 - k)};
      check($sformatf("t2_addr%0d", k), {59'd0, log_addr[wb + k]}, 64'(k));
      check($sformatf("t2_data%0d", k), {32'd0, log_data[wb + k]}, {32'd0, w});
    end
    check("t2_done_once", 64'(done_cnt - db), 64'd1);
    check("t2_hold_gaps", 64'(hold_bad), 64'd0);

    // 3: bad word counts.
    wb = wr_cnt; db = done_cnt;
    send(8'hA5, 0);
    send(8'h00, 0);
    @(negedge clk);
    check("t3_err_n0", {63'd0, err}, 64'd1);
    check("t3_hold_n0", {63'd0, cpu_hold}, 64'd0);
    send(8'h05, 0);  // would start a frame if still in COUNT
    @(negedge clk);
    check("t3_idle_n0", {63'd0, cpu_hold}, 64'd0);
    send(8'hA5, 0);
    check("t3_sync_clears_err", {63'd0, err}, 64'd0);
    send(8'h21, 0);
    @(negedge clk);
    check("t3_err_n33", {63'd0, err}, 64'd1);
    check("t3_hold_n33", {63'd0, cpu_hold}, 64'd0);
    check("t3_no_writes", 64'(wr_cnt - wb), 64'd0);
    check("t3_no_done", 64'(done_cnt - db), 64'd0);

`ifdef IMEM_LOADER_CSUM_EN
    // 4: wrong checksum.
    wb = wr_cnt; db = done_cnt; csum = 8'd0;
    send(8'hA5, 0);
    send(8'h01, 0);
    send_word(32'h1234_5678, 0);
    send(csum ^ 8'h01, 0);
    repeat (3) @(negedge clk);
    check("t4_writes", 64'(wr_cnt - wb), 64'd1);
    check("t4_data", {32'd0, log_data[wb]}, 64'h1234_5678);
    check("t4_no_done", 64'(done_cnt - db), 64'd0);
    check("t4_err", {63'd0, err}, 64'd1);
    check("t4_hold", {63'd0, cpu_hold}, 64'd0);
    send(8'hA5, 0);
    check("t4_sync_clears_err", {63'd0, err}, 64'd0);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
`endif

    // 5: abort after 2 of 3 words, then a good frame.
    wb = wr_cnt; db = done_cnt;
    send(8'hA5, 0);
    send(8'h03, 0);
    send_word(32'hAAAA_0001, 0);
    send_word(32'hAAAA_0002, 0);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    in_data = 8'h77;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("t5_hold_after_abort", {63'd0, cpu_hold}, 64'd0);
    check("t5_err_unchanged", {63'd0, err}, 64'd0);
    send(8'h11, 0);
    send(8'h22, 0);
    send(8'h33, 0);
    send(8'h44, 0);
    repeat (3) @(negedge clk);
    check("t5_two_writes", 64'(wr_cnt - wb), 64'd2);
    check("t5_w1_addr", {59'd0, log_addr[wb + 1]}, 64'd1);
    check("t5_no_done", 64'(done_cnt - db), 64'd0);
    wb = wr_cnt; db = done_cnt; csum = 8'd0;
    send(8'hA5, 0);
    send(8'h01, 0);
    send_word(32'hDEAD_BEEF, 0);
    send_csum();
    wait_done("t5_done_seen");
    check("t5_good_writes", 64'(wr_cnt - wb), 64'd1);
    check("t5_good_addr", {59'd0, log_addr[wb]}, 64'd0);
    check("t5_good_data", {32'd0, log_data[wb]}, 64'hDEAD_BEEF);
    check("t5_good_done", 64'(done_cnt - db), 64'd1);

    // 6: gaps, then asynchronous reset mid-DATA.
    wb = wr_cnt; db = done_cnt;
    send(8'hA5, $urandom_range(0, 3));
    send(8'h02, $urandom_range(0, 3));
    send(8'h9C, $urandom_range(0, 3));
    send(8'h5B, $urandom_range(0, 3));
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_hold", {63'd0, cpu_hold}, 64'd0);
    check("t6_rst_ready", {63'd0, in_ready}, 64'd1);
    check("t6_rst_we", {63'd0, imem_we}, 64'd0);
    check("t6_rst_waddr", {59'd0, imem_waddr}, 64'd0);
    check("t6_rst_wdata", {32'd0, imem_wdata}, 64'd0);
    check("t6_rst_err", {63'd0, err}, 64'd0);
    check("t6_rst_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    send(8'h01, $urandom_range(0, 2));
    send(8'h02, $urandom_range(0, 2));
    repeat (3) @(negedge clk);
    check("t6_no_writes", 64'(wr_cnt - wb), 64'd0);
    check("t6_no_done", 64'(done_cnt - db), 64'd0);
    check("t6_idle_hold", {63'd0, cpu_hold}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
